pds_rx_buffer: RTL
==================

Name: pds_rx_buffer

Overview:
Downstream stage of the pds increment datapath. It absorbs the valid-only output stream of that stage (data_op/valid_op, which has no backpressure) into a DEPTH-entry first-word-fall-through FIFO. It re-presents the data on a ready/valid interface to the consumer (scoreboard-facing sink or next pipeline stage). Overflow is detected, counted and flagged, never silently ignored.

Parameters:
DATA_W, 8, width of in_data/out_data; matches the pds data width
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream valid (driven from valid_op)
in_data  input  DATA_W  upstream data (driven from data_op)
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head this cycle
out_data  output  DATA_W  head entry; 0 when out_valid=0
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  level==DEPTH
empty  output  1  level==0
overflow  output  1  sticky: at least one word dropped
clear_ovf  input  1  clears overflow
drop_cnt  output  CNT_W  number of dropped words, saturating

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, sampled on posedge clk only.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_data=0, full=0, empty=1, overflow=0, drop_cnt=0. Storage contents need no reset.
- Reset mid-operation discards all stored words. The first post-reset push is accepted normally on the first cycle reset is low.
- push = in_valid && (!full || pop); pop = out_valid && out_ready.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr. Pointers wrap modulo DEPTH.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed in cycle N is visible at out_valid/out_data in cycle N+1 when the FIFO was empty. There is no same-cycle bypass.
- out_valid = !empty. out_data = mem[rd_ptr] gated to 0 when empty. out_data stays stable while out_valid=1 and out_ready=0.
- Full with simultaneous pop: the push is accepted, level stays DEPTH, nothing is dropped.
- Full without pop and in_valid=1: the word is dropped, overflow is set next cycle, and drop_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- clear_ovf=1 clears overflow next cycle. If a drop occurs in the same cycle, set wins and overflow stays 1. clear_ovf does not clear drop_cnt; only reset does.
- out_ready while empty has no effect. Pointers and level never change on a non-pop.
- Invariant: level never exceeds DEPTH and never underflows. Order is strictly preserved.

Decomposition:
- Shared package pds_pkg:
  - DATA_W default constant.
  - typedef data_t = logic [DATA_W-1:0].
  - Localparams for pointer width (PTR_W=$clog2(DEPTH)) and level width.
  - Shared with the increment stage and the UVM env.
- One sub-module, pds_buf_mem:
  - DEPTH x DATA_W storage array.
  - Synchronous write port and asynchronous read port.
  - Holds no control state.
- pds_rx_buffer holds pointers, level, flags and counter.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> empty=1, full=0, level=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0.
- Single word latency: in_valid=1, in_data=8'h05 at cycle N, out_ready=0 -> at N+1 out_valid=1, out_data=8'h05, level=1. Raise out_ready at N+1 -> at N+2 empty=1.
- Fill and hold order: push 8'h01..8'h04 on consecutive cycles with out_ready=0 -> full=1, level=4. Then out_ready=1 -> out_data sequence 01,02,03,04, then empty=1.
- Overflow: fill with 01..04, push 8'hAA and 8'hBB with out_ready=0 -> overflow=1, drop_cnt=2, and drained data is 01..04 only. Pulse clear_ovf -> overflow=0, drop_cnt stays 2.
- Full with concurrent pop: full (01..04), in_valid=1 with 8'h10 and out_ready=1 in the same cycle -> level stays 4, drop_cnt unchanged, drain order 02,03,04,10.
- Reset mid-stream and saturation:
  - Reset asserted with level=3 -> next cycle empty=1 and the old data is never seen.
  - Separately, with CNT_W=2, force 5 drops -> drop_cnt=3, and clear_ovf together with a drop -> overflow stays 1.

Source files
------------

// File: rtl/pds_pkg.sv
// Shared definitions for the pds datapath: default widths, the data word type
// and the derived pointer/level widths used by the receive buffer.
package pds_pkg;

    localparam int PDS_DATA_W = 8;
    localparam int PDS_DEPTH  = 4;
    localparam int PDS_CNT_W  = 8;
    localparam int PDS_PTR_W  = $clog2(PDS_DEPTH);
    localparam int PDS_LVL_W  = PDS_PTR_W + 1;

    typedef logic [PDS_DATA_W-1:0] data_t;

endpackage

// File: rtl/pds_buf_mem.sv
// Storage array for the receive buffer: synchronous write, asynchronous read.
// Holds no control state; contents are not reset.
module pds_buf_mem
    import pds_pkg::*;
#(
    parameter int DATA_W = PDS_DATA_W,
    parameter int DEPTH  = PDS_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pds_rx_buffer.sv
// First-word-fall-through receive buffer: absorbs a valid-only stream and re-presents
// it on ready/valid, counting and flagging any words dropped while full.
module pds_rx_buffer
    import pds_pkg::*;
#(
    parameter int DATA_W = PDS_DATA_W,
    parameter int DEPTH  = PDS_DEPTH,
    parameter int CNT_W  = PDS_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [DATA_W-1:0] w_rd_data;

    // Output handshake: a word transfers on a cycle where out_valid and out_ready are
    // both high; out_data holds steady while out_valid=1 and out_ready=0. The input
    // side has no backpressure, so a full buffer may still accept when it pops.
    assign w_pop  = out_valid && out_ready;
    assign w_push = in_valid && (!full || w_pop);
    assign w_drop = in_valid && full && !w_pop;

    pds_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign level     = r_level;
    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : w_rd_data;
    assign overflow  = r_ovf;
    assign drop_cnt  = r_drop_cnt;

endmodule
